// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: controller state codes, timer FSM states
// and default phase durations.
package wm_pkg;

    localparam logic [2:0] CTL_START      = 3'd0;
    localparam logic [2:0] CTL_FILL_WATER = 3'd1;
    localparam logic [2:0] CTL_HEAT_WATER = 3'd2;
    localparam logic [2:0] CTL_WASH       = 3'd3;
    localparam logic [2:0] CTL_RINSE      = 3'd4;
    localparam logic [2:0] CTL_SPIN       = 3'd5;
    localparam logic [2:0] CTL_HOLD       = 3'd6;
    localparam logic [2:0] CTL_FAULT      = 3'd7;

    typedef enum logic [2:0] {
        T_IDLE,
        T_FILL,
        T_HEAT,
        T_WASH,
        T_RINSE,
        T_SPIN,
        T_EXPIRED
    } timer_state_t;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_CLK_DIV      = 1000;
    localparam int DEF_FILL_TIMEOUT = 60;
    localparam int DEF_HEAT_TIMEOUT = 120;
    localparam int DEF_WASH_TICKS   = 300;
    localparam int DEF_RINSE_TICKS  = 200;
    localparam int DEF_SPIN_TICKS   = 150;

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides the system clock by CLK_DIV; tick is asserted combinationally on the
// enabled cycle where the divider wraps.
module wm_tick_prescaler #(
    parameter int CLK_DIV = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] count;

    assign tick = enable && !clear && (count == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Per-phase countdown scheduler for the washing-machine controller.
// Optional macro WM_EXTRA_RINSE_EN adds extra_Rinse (doubles the rinse load).
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
    parameter int HEAT_TIMEOUT = DEF_HEAT_TIMEOUT,
    parameter int WASH_TICKS   = DEF_WASH_TICKS,
    parameter int RINSE_TICKS  = DEF_RINSE_TICKS,
    parameter int SPIN_TICKS   = DEF_SPIN_TICKS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             fill_Water_Operation,
    input  logic             heat_Water_Operation,
    input  logic             wash_Operation,
    input  logic             rinse_Operation,
    input  logic             spin_Operation,
    input  logic             pause,
`ifdef WM_EXTRA_RINSE_EN
    input  logic             extra_Rinse,
`endif
    output logic             sig_Time_Out,
    output logic             sig_Wash_Completed,
    output logic             sig_Rinse_Completed,
    output logic             sig_Spin_Completed,
    output logic             phase_Error,
    output logic [CNT_W-1:0] remaining_Ticks
);

    localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_TIMEOUT);
    localparam logic [CNT_W-1:0] HEAT_LOAD  = CNT_W'(HEAT_TIMEOUT);
    localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_TICKS);
    localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_TICKS);
    localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_TICKS);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

`ifdef WM_EXTRA_RINSE_EN
    function automatic logic [CNT_W-1:0] sat_double(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] d;
        d = {v, 1'b0};
        return d[CNT_W] ? '1 : d[CNT_W-1:0];
    endfunction
`endif

    timer_state_t     state;
    timer_state_t     entry_state;
    logic [4:0]       ops_p0, ops_p1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] entry_load;
    logic             multi, go_idle, entry, run_phase, counting, expire;
    logic             pre_clear, pre_enable, tick;

    // Stage p0: current operation sample; p1 holds the previous edge's sample
    assign ops_p0  = {fill_Water_Operation, heat_Water_Operation, wash_Operation,
                      rinse_Operation, spin_Operation};
    assign multi   = (ops_p0 & (ops_p0 - 5'd1)) != 5'd0;
    assign go_idle = multi || (ops_p0 == 5'd0);
    assign entry   = !go_idle && (ops_p0 != ops_p1);

    always_comb begin
        entry_state = T_IDLE;
        entry_load  = '0;
        case (ops_p0)
            5'b10000: begin entry_state = T_FILL;  entry_load = FILL_LOAD;  end
            5'b01000: begin entry_state = T_HEAT;  entry_load = HEAT_LOAD;  end
            5'b00100: begin entry_state = T_WASH;  entry_load = WASH_LOAD;  end
            5'b00010: begin
                entry_state = T_RINSE;
`ifdef WM_EXTRA_RINSE_EN
                entry_load  = extra_Rinse ? sat_double(RINSE_LOAD) : RINSE_LOAD;
`else
                entry_load  = RINSE_LOAD;
`endif
            end
            5'b00001: begin entry_state = T_SPIN;  entry_load = SPIN_LOAD;  end
            default:  begin entry_state = T_IDLE;  entry_load = '0;         end
        endcase
    end

    // Fill/heat with a zero timeout sit idle; the duration phases expire even from 0
    assign run_phase  = (state == T_WASH) || (state == T_RINSE) || (state == T_SPIN);
    assign counting   = run_phase ||
                        (((state == T_FILL) || (state == T_HEAT)) && (count != '0));
    assign pre_clear  = go_idle || entry || !counting;
    assign pre_enable = counting && !pause;
    assign expire     = !go_idle && !entry && counting && !pause &&
                        ((tick && (count == ONE)) || (run_phase && (count == '0)));

    wm_tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (pre_clear),
        .enable  (pre_enable),
        .tick    (tick)
    );

    assign remaining_Ticks = count;

    // Stage p1: FSM, counter and registered pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= T_IDLE;
            ops_p1              <= '0;
            count               <= '0;
            phase_Error         <= 1'b0;
            sig_Time_Out        <= 1'b0;
            sig_Wash_Completed  <= 1'b0;
            sig_Rinse_Completed <= 1'b0;
            sig_Spin_Completed  <= 1'b0;
        end else begin
            ops_p1              <= ops_p0;
            phase_Error         <= phase_Error | multi;
            sig_Time_Out        <= 1'b0;
            sig_Wash_Completed  <= 1'b0;
            sig_Rinse_Completed <= 1'b0;
            sig_Spin_Completed  <= 1'b0;
            if (go_idle) begin
                state <= T_IDLE;
                count <= '0;
            end else if (entry) begin
                state <= entry_state;
                count <= entry_load;
            end else if (expire) begin
                state               <= T_EXPIRED;
                count               <= '0;
                sig_Time_Out        <= (state == T_FILL) || (state == T_HEAT);
                sig_Wash_Completed  <= (state == T_WASH);
                sig_Rinse_Completed <= (state == T_RINSE);
                sig_Spin_Completed  <= (state == T_SPIN);
            end else if (tick && (count != '0)) begin
                count <= count - ONE;
            end
        end
    end

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer with CLK_DIV=4 and short phase durations.
module tb_wm_phase_timer;

    logic        clock;
    logic        reset_n;
    logic        fill_op, heat_op, wash_op, rinse_op, spin_op, pause;
`ifdef WM_EXTRA_RINSE_EN
    logic        extra_Rinse;
`endif
    logic        time_out, wash_done, rinse_done, spin_done, phase_err;
    logic [15:0] remaining;

    int total = 0;
    int bad   = 0;

    wm_phase_timer #(
        .CNT_W(16), .CLK_DIV(4), .FILL_TIMEOUT(5), .HEAT_TIMEOUT(0),
        .WASH_TICKS(3), .RINSE_TICKS(3), .SPIN_TICKS(3)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .fill_Water_Operation (fill_op),
        .heat_Water_Operation (heat_op),
        .wash_Operation       (wash_op),
        .rinse_Operation      (rinse_op),
        .spin_Operation       (spin_op),
        .pause                (pause),
`ifdef WM_EXTRA_RINSE_EN
        .extra_Rinse          (extra_Rinse),
`endif
        .sig_Time_Out         (time_out),
        .sig_Wash_Completed   (wash_done),
        .sig_Rinse_Completed  (rinse_done),
        .sig_Spin_Completed   (spin_done),
        .phase_Error          (phase_err),
        .remaining_Ticks      (remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {fill_op, heat_op, wash_op, rinse_op, spin_op, pause} = '0;
`ifdef WM_EXTRA_RINSE_EN
        extra_Rinse = 1'b0;
`endif
        #1;
        chk("reset_pulses", {28'd0, time_out, wash_done, rinse_done, spin_done}, 0);
        chk("reset_err", phase_err, 0);
        chk("reset_remaining", remaining, 0);
        step(); step();
        reset_n = 1'b1;
        step();
        chk("idle_remaining", remaining, 0);

        // Wash: 3 ticks of 4 cycles, pulse at E+12
        wash_op = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            chk($sformatf("wash_rem_k%0d", k), remaining, (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0);
            chk($sformatf("wash_pulse_k%0d", k), wash_done, (k == 12) ? 1 : 0);
            chk($sformatf("wash_other_k%0d", k), time_out + rinse_done + spin_done, 0);
        end
        wash_op = 1'b0;
        step();
        chk("wash_drop_rem", remaining, 0);

        // Fill timeout 5 ticks -> E+20, held input never re-triggers
        fill_op = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            step();
            if (k == 0) chk("fill_load", remaining, 5);
            chk($sformatf("fill_pulse_k%0d", k), time_out, (k == 20) ? 1 : 0);
        end
        fill_op = 1'b0;
        step();

        // Heat timeout 0: never times out, counter idle
        heat_op = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            step();
            chk($sformatf("heat_pulse_k%0d", k), time_out, 0);
            if (k % 10 == 0) chk($sformatf("heat_rem_k%0d", k), remaining, 0);
        end
        heat_op = 1'b0;
        step();

        // Rinse with pause sampled high on edges E+5..E+11 -> pulse at E+19
        rinse_op = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            step();
            chk($sformatf("rinse_pulse_k%0d", k), rinse_done, (k == 19) ? 1 : 0);
            if (k == 11) chk("rinse_paused_rem", remaining, 2);
            if (k == 15) chk("rinse_resume_rem", remaining, 1);
            if (k == 4) pause = 1'b1;
            if (k == 11) pause = 1'b0;
        end
        rinse_op = 1'b0;
        step();

        // Spin dropped at E+6, reasserted at E+8 -> reload, pulse at E+20
        spin_op = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            step();
            chk($sformatf("spin_pulse_k%0d", k), spin_done, (k == 20) ? 1 : 0);
            if (k == 6) chk("spin_drop_rem", remaining, 0);
            if (k == 8) chk("spin_reload_rem", remaining, 3);
            if (k == 5) spin_op = 1'b0;
            if (k == 7) spin_op = 1'b1;
        end
        spin_op = 1'b0;
        step();
        chk("pre_error_flag", phase_err, 0);

`ifdef WM_EXTRA_RINSE_EN
        extra_Rinse = 1'b1;
        rinse_op = 1'b1;
        for (int k = 0; k <= 28; k++) begin
            step();
            if (k == 0) chk("xrinse_load", remaining, 6);
            chk($sformatf("xrinse_pulse_k%0d", k), rinse_done, (k == 24) ? 1 : 0);
        end
        rinse_op = 1'b0;
        step();
        extra_Rinse = 1'b0;
        rinse_op = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            chk($sformatf("nrinse_pulse_k%0d", k), rinse_done, (k == 12) ? 1 : 0);
        end
        rinse_op = 1'b0;
        step();
`endif

        // Two operations high: error latched, idle, no pulses
        wash_op = 1'b1;
        spin_op = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("multi_err_k%0d", k), phase_err, 1);
            chk($sformatf("multi_rem_k%0d", k), remaining, 0);
            chk($sformatf("multi_pulses_k%0d", k), time_out + wash_done + rinse_done + spin_done, 0);
        end
        spin_op = 1'b0;
        step();
        chk("multi_exit_load", remaining, 3);
        chk("err_sticky", phase_err, 1);
        for (int k = 1; k <= 5; k++) step();
        chk("midcount_rem", remaining, 2);

        // Asynchronous reset away from the clock edge
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_rem", remaining, 0);
        chk("async_rst_err", phase_err, 0);
        chk("async_rst_pulses", {28'd0, time_out, wash_done, rinse_done, spin_done}, 0);
        wash_op = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_rem", remaining, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
- Timing scheduler that paces the washing-machine FSM.
- Watches the one-hot operation outputs (fill/heat/wash/rinse/spin) and runs a per-phase countdown on a prescaled tick.
- Drives the FSM's phase inputs as single-cycle pulses: sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed.
- Sits between the controller outputs and controller inputs, replacing board-level timers.

Parameters:
- CNT_W, 16, width of the tick counter and the remaining_Ticks output.
- CLK_DIV, 1000, clock cycles per tick (>=1).
- FILL_TIMEOUT, 60, ticks allowed for fill before a sig_Time_Out pulse; 0 disables.
- HEAT_TIMEOUT, 120, ticks allowed for heat before a sig_Time_Out pulse; 0 disables.
- WASH_TICKS, 300, wash duration in ticks.
- RINSE_TICKS, 200, rinse duration in ticks.
- SPIN_TICKS, 150, spin duration in ticks.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fill_Water_Operation  in  1  controller in fill phase.
- heat_Water_Operation  in  1  controller in heat phase.
- wash_Operation  in  1  controller in wash phase.
- rinse_Operation  in  1  controller in rinse phase.
- spin_Operation  in  1  controller in spin phase.
- pause  in  1  freeze prescaler and counter (lid opened, service hold).
- sig_Time_Out  out  1  one-cycle pulse on fill/heat timeout.
- sig_Wash_Completed  out  1  one-cycle pulse at end of wash.
- sig_Rinse_Completed  out  1  one-cycle pulse at end of rinse.
- sig_Spin_Completed  out  1  one-cycle pulse at end of spin.
- phase_Error  out  1  sticky: more than one operation input was seen high.
- remaining_Ticks  out  CNT_W  ticks left in the current phase; 0 when idle or expired.

Behaviour:
- Reset (async, reset_n=0): all pulse outputs 0; phase_Error 0; remaining_Ticks 0; prescaler 0; FSM IDLE.
- FSM states: IDLE, FILL, HEAT, WASH, RINSE, SPIN, EXPIRED.
- Operation inputs are sampled every rising edge.
- Phase entry: at edge E the sampled one-hot code differs from the previous sample and is non-zero. The FSM moves to the matching state, loads the counter with that phase's parameter, and clears the prescaler.
- Entry is evaluated from any state, including mid-countdown and EXPIRED, so a new phase always restarts timing.
- Tick generation: the prescaler counts 0..CLK_DIV-1 while in a counting state with pause=0. A tick is issued when it wraps.
- Countdown: each tick decrements the counter; it saturates at 0 and never wraps.
- Expiry: the counter reaches 0 on the edge at E+N*CLK_DIV (N = loaded value, no pause). On that same edge:
  - the phase output is registered high for exactly one cycle;
  - the FSM enters EXPIRED.
- Phase-to-output mapping: FILL/HEAT -> sig_Time_Out; WASH -> sig_Wash_Completed; RINSE -> sig_Rinse_Completed; SPIN -> sig_Spin_Completed.
- EXPIRED: no further pulses until a new phase entry; holding the same operation input never re-triggers.
- Zero load:
  - FILL/HEAT with timeout 0: the phase never times out; counter idle; remaining_Ticks=0.
  - WASH/RINSE/SPIN with 0: pulse on edge E+1.
- All operation inputs low: FSM returns to IDLE next edge; counter cleared; no pulse. Any in-flight expiry on that same edge is suppressed.
- Two or more operation inputs high: treated as all-low (IDLE); phase_Error set. phase_Error clears only on reset.
- pause=1: prescaler and counter hold their values, and pulses are blocked. After release, counting resumes from the held prescaler value, so total latency grows by the paused cycle count.
- Phase entry takes priority over pause: the counter still loads while paused.
- At most one pulse output is high in any cycle.
- remaining_Ticks is the registered counter value.

Optional Feature:
- Macro: WM_EXTRA_RINSE_EN.
- Defined: adds input port extra_Rinse (1 bit), sampled at RINSE entry. If high, the counter loads 2*RINSE_TICKS, computed at CNT_W+1 bits and saturated to 2^CNT_W-1.
- Undefined: the port is absent and rinse always loads RINSE_TICKS.

Decomposition:
- Shared package wm_pkg holds:
  - 3-bit state encodings shared with the controller (START=0 … FAULT=7);
  - the timer FSM state enum;
  - default duration constants.
- One sub-module, wm_tick_prescaler, owns the CLK_DIV counter. It has clear, enable and tick-out; reset is async active-low.

Test Plan:
- CLK_DIV=4, WASH_TICKS=3; assert wash_Operation at edge E -> sig_Wash_Completed high for one cycle at E+12; remaining_Ticks steps 3,2,1,0 at E, E+4, E+8, E+12.
- CLK_DIV=2, FILL_TIMEOUT=5; hold fill with no change -> sig_Time_Out pulse at E+10, then no further pulse over 50 cycles.
- CLK_DIV=4, RINSE_TICKS=3; pause high for 7 cycles starting at E+5 -> sig_Rinse_Completed at E+19.
- SPIN_TICKS=3, CLK_DIV=4; drop spin_Operation at E+6, reassert at E+8 -> counter reloads to 3; pulse at E+20, none at E+12.
- Drive wash_Operation and spin_Operation together -> phase_Error=1, state IDLE, no pulses; reset_n low mid-count -> all outputs 0 immediately, without waiting for a clock edge.
- With WM_EXTRA_RINSE_EN, CLK_DIV=1, RINSE_TICKS=4, extra_Rinse=1 -> pulse at E+8; with extra_Rinse=0 -> pulse at E+4.
